// File: rtl/fixed_subframe_sequencer_pkg.sv
// Shared types and constants for the FLAC fixed-subframe sequencer.
package fixed_subframe_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_METHOD,
        S_PORDER,
        S_PARAM,
        S_RESIDUAL,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] RES_RICE4 = 2'b00;
    localparam logic [1:0] RES_RICE5 = 2'b01;

    localparam logic [3:0] ESC4 = 4'hF;
    localparam logic [4:0] ESC5 = 5'h1F;

    localparam int MAX_ORDER = 4;

endpackage

// File: rtl/fixed_subframe_sequencer_partition_count.sv
// Residual count of one Rice partition; partition 0 loses the warm-up samples.
module partition_count #(
    parameter int BS_W = 16
) (
    input  logic [BS_W-1:0] blocksize_i,
    input  logic [3:0]      porder_i,
    input  logic [2:0]      order_i,
    input  logic            first_i,
    output logic [BS_W-1:0] count_o,
    output logic            underflow_o
);

    logic [BS_W-1:0] base;
    logic [BS_W:0]   diff;

    always_comb begin
        base        = blocksize_i >> porder_i;
        diff        = {1'b0, base} - (first_i ? (BS_W+1)'(order_i) : '0);
        count_o     = diff[BS_W-1:0];
        underflow_o = diff[BS_W];
    end

endmodule

// File: rtl/fixed_subframe_sequencer.sv
// Bit-serial control FSM for a FLAC SUBFRAME_FIXED: warm-up, residual header,
// per-partition Rice parameters and residual hand-off to the Rice decoder.
module fixed_subframe_sequencer
    import fixed_subframe_sequencer_pkg::*;
#(
    parameter int BPS  = 16,
    parameter int BS_W = 16
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iStart,
    input  logic [2:0]      iOrder,
    input  logic [BS_W-1:0] iBlockSize,
    input  logic            iData,
    input  logic            iRiceDone,
    output logic            oBusy,
    output logic [BPS-1:0]  oWarmupSample,
    output logic            oWarmupValid,
    output logic [4:0]      oRiceParam,
    output logic            oRiceEnable,
    output logic            oPredEnable,
    output logic            oDone,
    output logic            oError
);

    localparam int BC_MAX = (BPS > 5) ? BPS : 5;
    localparam int BCW    = $clog2(BC_MAX);

    state_e          state_q, state_d;
    logic [BS_W-1:0] bs_q, bs_d;
    logic [2:0]      order_q, order_d;
    logic [2:0]      wleft_q, wleft_d;
    logic [BCW-1:0]  bitcnt_q, bitcnt_d;
    logic [BPS-2:0]  shift_q, shift_d;
    logic [BPS-1:0]  wsample_q, wsample_d;
    logic            wvalid_q, wvalid_d;
    logic            rice5_q, rice5_d;
    logic [3:0]      porder_q, porder_d;
    logic [15:0]     part_q, part_d;
    logic [BS_W-1:0] rem_q, rem_d;
    logic [4:0]      param_q, param_d;

    // One shifter serves every field; the newest bit is always sh_in[0].
    logic [BPS-1:0]  sh_in;
    logic [3:0]      pc_porder;
    logic            pc_first;
    logic [BS_W-1:0] pc_count;
    logic            pc_underflow;
    logic            last_part;
    logic            par_last;
    logic            par_esc;
    logic [4:0]      par_val;

    assign sh_in     = {shift_q, iData};
    assign pc_first  = (state_q == S_PORDER);
    assign pc_porder = pc_first ? sh_in[3:0] : porder_q;
    assign last_part = (part_q == ((16'(1) << porder_q) - 16'd1));
    assign par_last  = (bitcnt_q == (rice5_q ? BCW'(4) : BCW'(3)));
    assign par_val   = rice5_q ? sh_in[4:0] : {1'b0, sh_in[3:0]};
    assign par_esc   = rice5_q ? (sh_in[4:0] == ESC5) : (sh_in[3:0] == ESC4);

    partition_count #(.BS_W(BS_W)) u_pcount (
        .blocksize_i (bs_q),
        .porder_i    (pc_porder),
        .order_i     (order_q),
        .first_i     (pc_first),
        .count_o     (pc_count),
        .underflow_o (pc_underflow)
    );

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q   <= S_IDLE;
            bs_q      <= '0;
            order_q   <= '0;
            wleft_q   <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            wsample_q <= '0;
            wvalid_q  <= 1'b0;
            rice5_q   <= 1'b0;
            porder_q  <= '0;
            part_q    <= '0;
            rem_q     <= '0;
            param_q   <= '0;
        end else begin
            state_q   <= state_d;
            bs_q      <= bs_d;
            order_q   <= order_d;
            wleft_q   <= wleft_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            wsample_q <= wsample_d;
            wvalid_q  <= wvalid_d;
            rice5_q   <= rice5_d;
            porder_q  <= porder_d;
            part_q    <= part_d;
            rem_q     <= rem_d;
            param_q   <= param_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bs_d      = bs_q;
        order_d   = order_q;
        wleft_d   = wleft_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        wsample_d = wsample_q;
        wvalid_d  = 1'b0;
        rice5_d   = rice5_q;
        porder_d  = porder_q;
        part_d    = part_q;
        rem_d     = rem_q;
        param_d   = param_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart) begin
                    bs_d     = iBlockSize;
                    order_d  = iOrder;
                    wleft_d  = iOrder;
                    bitcnt_d = '0;
                    // Orders above the fixed-predictor maximum are not decodable.
                    if (iOrder > 3'(MAX_ORDER))
                        state_d = S_ERROR;
                    else if (iOrder == 3'd0)
                        state_d = S_METHOD;
                    else
                        state_d = S_WARMUP;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_WARMUP: begin
                shift_d  = sh_in[BPS-2:0];
                bitcnt_d = bitcnt_q + BCW'(1);
                if (bitcnt_q == BCW'(BPS-1)) begin
                    bitcnt_d  = '0;
                    wsample_d = sh_in;
                    wvalid_d  = 1'b1;
                    wleft_d   = wleft_q - 3'd1;
                    if (wleft_q == 3'd1)
                        state_d = S_METHOD;
                end
            end

            S_METHOD: begin
                shift_d  = sh_in[BPS-2:0];
                bitcnt_d = bitcnt_q + BCW'(1);
                if (bitcnt_q == BCW'(1)) begin
                    bitcnt_d = '0;
                    case (sh_in[1:0])
                        RES_RICE4: begin rice5_d = 1'b0; state_d = S_PORDER; end
                        RES_RICE5: begin rice5_d = 1'b1; state_d = S_PORDER; end
                        default:   state_d = S_ERROR;
                    endcase
                end
            end

            S_PORDER: begin
                shift_d  = sh_in[BPS-2:0];
                bitcnt_d = bitcnt_q + BCW'(1);
                if (bitcnt_q == BCW'(3)) begin
                    bitcnt_d = '0;
                    porder_d = sh_in[3:0];
                    part_d   = '0;
                    rem_d    = pc_count;
                    state_d  = pc_underflow ? S_ERROR : S_PARAM;
                end
            end

            S_PARAM: begin
                shift_d  = sh_in[BPS-2:0];
                bitcnt_d = bitcnt_q + BCW'(1);
                if (par_last) begin
                    bitcnt_d = '0;
                    if (par_esc) begin
                        state_d = S_ERROR;
                    end else begin
                        param_d = par_val;
                        if (rem_q != '0) begin
                            state_d = S_RESIDUAL;
                        end else if (last_part) begin
                            state_d = S_DONE;
                        end else begin
                            // Empty partition: its parameter is read but no residuals follow.
                            part_d = part_q + 16'd1;
                            rem_d  = pc_count;
                        end
                    end
                end
            end

            S_RESIDUAL: begin
                if (iRiceDone) begin
                    rem_d = rem_q - BS_W'(1);
                    if (rem_q == BS_W'(1)) begin
                        if (last_part) begin
                            state_d = S_DONE;
                        end else begin
                            part_d  = part_q + 16'd1;
                            rem_d   = pc_count;
                            state_d = S_PARAM;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign oBusy         = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign oWarmupSample = wsample_q;
    assign oWarmupValid  = wvalid_q;
    assign oRiceParam    = param_q;
    assign oRiceEnable   = (state_q == S_RESIDUAL);
    assign oPredEnable   = wvalid_q | (oRiceEnable & iRiceDone);
    assign oDone         = (state_q == S_DONE);
    assign oError        = (state_q == S_ERROR);

endmodule

// File: tb/tb_fixed_subframe_sequencer.sv
// Directed bench for fixed_subframe_sequencer: hand-built bitstreams, per-cycle capture.
module tb_fixed_subframe_sequencer;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iStart = 1'b0;
    logic [2:0]  iOrder = '0;
    logic [15:0] iBlockSize = '0;
    logic        iData = 1'b0;
    logic        iRiceDone = 1'b0;
    logic        oBusy, oWarmupValid, oRiceEnable, oPredEnable, oDone, oError;
    logic [15:0] oWarmupSample;
    logic [4:0]  oRiceParam;

    fixed_subframe_sequencer #(.BPS(16), .BS_W(16)) dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iStart        (iStart),
        .iOrder        (iOrder),
        .iBlockSize    (iBlockSize),
        .iData         (iData),
        .iRiceDone     (iRiceDone),
        .oBusy         (oBusy),
        .oWarmupSample (oWarmupSample),
        .oWarmupValid  (oWarmupValid),
        .oRiceParam    (oRiceParam),
        .oRiceEnable   (oRiceEnable),
        .oPredEnable   (oPredEnable),
        .oDone         (oDone),
        .oError        (oError)
    );

    always #5 iClock = ~iClock;

    int ncmp = 0;
    int nerr = 0;

    logic        s_busy, s_wv, s_ren, s_pe, s_done, s_err;
    logic [15:0] s_ws;
    logic [4:0]  s_rp;

    int          n_pe, n_ren, n_done, n_busy, cur;
    logic        prev_ren = 1'b0;
    logic [15:0] wq[$];
    int          pq[$];
    int          cq[$];

    task automatic clr();
        n_pe = 0; n_ren = 0; n_done = 0; n_busy = 0; cur = 0;
        wq.delete(); pq.delete(); cq.delete();
    endtask

    // One clock: drive, sample at the falling edge, tally events, then cross the rising edge.
    task automatic cyc(input logic d, input logic rd);
        iData = d;
        iRiceDone = rd;
        @(negedge iClock);
        s_busy = oBusy; s_wv = oWarmupValid; s_ren = oRiceEnable; s_pe = oPredEnable;
        s_done = oDone; s_err = oError; s_ws = oWarmupSample; s_rp = oRiceParam;
        if (oWarmupValid) wq.push_back(oWarmupSample);
        if (oPredEnable) n_pe++;
        if (oRiceEnable) n_ren++;
        if (oDone) n_done++;
        if (oBusy) n_busy++;
        if (oRiceEnable && !prev_ren) pq.push_back(int'(oRiceParam));
        if (oRiceEnable && iRiceDone) cur++;
        if (!oRiceEnable && prev_ren) begin cq.push_back(cur); cur = 0; end
        prev_ren = oRiceEnable;
        @(posedge iClock);
        #1;
        iStart = 1'b0;
    endtask

    task automatic bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(v[i], 1'b0);
    endtask

    // Each residual takes two stream bits; the second completes it.
    task automatic res(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b1);
        end
    endtask

    task automatic start(input logic [2:0] o, input logic [15:0] b);
        iStart = 1'b1;
        iOrder = o;
        iBlockSize = b;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        iReset = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        ncmp++;
        if ({s_busy, s_wv, s_ren, s_pe, s_done, s_err} !== 6'b0 || s_ws !== 16'h0 || s_rp !== 5'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got flags=%b ws=%h rp=%0d expected all zero",
                     {s_busy, s_wv, s_ren, s_pe, s_done, s_err}, s_ws, s_rp);
        end
        iReset = 1'b1;
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_busy !== 1'b0) begin nerr++; $display("FAIL reset_idle: busy=%b expected 0", s_busy); end
    endtask

    task automatic run_basic();
        clr();
        start(3'd2, 16'd8);
        bits(32'h0005, 16);
        bits(32'hFFFB, 16);
        bits(32'h0, 2);
        bits(32'h0, 4);
        bits(32'h3, 4);
        res(6);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            nerr++; $display("FAIL basic_done_latency: done=%b busy=%b expected 1/0", s_done, s_busy);
        end
        cyc(1'b0, 1'b0);
        ncmp++;
        if (wq.size() != 2 || wq[0] !== 16'h0005 || wq[1] !== 16'hFFFB) begin
            nerr++; $display("FAIL basic_warmup: n=%0d s0=%h s1=%h expected 2 0005 fffb", wq.size(), wq[0], wq[1]);
        end
        ncmp++;
        if (n_ren != 12 || cq.size() != 1 || cq[0] != 6 || pq[0] != 3) begin
            nerr++; $display("FAIL basic_residuals: ren=%0d parts=%0d cnt=%0d param=%0d expected 12 1 6 3",
                             n_ren, cq.size(), cq[0], pq[0]);
        end
        ncmp++;
        if (n_pe != 8 || n_done != 1 || n_busy != 54) begin
            nerr++; $display("FAIL basic_totals: pred=%0d done=%0d busy=%0d expected 8 1 54", n_pe, n_done, n_busy);
        end
    endtask

    task automatic test_basic();
        run_basic();
    endtask

    task automatic test_partitions();
        clr();
        start(3'd1, 16'd16);
        bits(32'h8000, 16);
        bits(32'h0, 2);
        bits(32'h2, 4);
        bits(32'h2, 4); res(3);
        bits(32'h3, 4); res(4);
        bits(32'h4, 4); res(4);
        bits(32'h5, 4); res(4);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_done !== 1'b1) begin nerr++; $display("FAIL part_done: done=%b expected 1", s_done); end
        ncmp++;
        if (pq.size() != 4 || pq[0] != 2 || pq[1] != 3 || pq[2] != 4 || pq[3] != 5) begin
            nerr++; $display("FAIL part_params: n=%0d %0d %0d %0d %0d expected 4 2 3 4 5",
                             pq.size(), pq[0], pq[1], pq[2], pq[3]);
        end
        ncmp++;
        if (cq.size() != 4 || cq[0] != 3 || cq[1] != 4 || cq[2] != 4 || cq[3] != 4) begin
            nerr++; $display("FAIL part_counts: n=%0d %0d %0d %0d %0d expected 4 3 4 4 4",
                             cq.size(), cq[0], cq[1], cq[2], cq[3]);
        end
        ncmp++;
        if (n_busy != 68 || n_pe != 16 || wq.size() != 1 || wq[0] !== 16'h8000) begin
            nerr++; $display("FAIL part_totals: busy=%0d pred=%0d nw=%0d w0=%h expected 68 16 1 8000",
                             n_busy, n_pe, wq.size(), wq[0]);
        end
    endtask

    task automatic test_method_error();
        clr();
        start(3'd0, 16'd4);
        bits(32'h2, 2);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_err !== 1'b1 || s_busy !== 1'b0) begin
            nerr++; $display("FAIL method_err: err=%b busy=%b expected 1/0", s_err, s_busy);
        end
        cyc(1'b1, 1'b1);
        ncmp++;
        if (s_err !== 1'b1 || s_ren !== 1'b0 || s_pe !== 1'b0) begin
            nerr++; $display("FAIL err_sticky: err=%b ren=%b pe=%b expected 1 0 0", s_err, s_ren, s_pe);
        end
        clr();
        start(3'd0, 16'd2);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_err !== 1'b0 || s_busy !== 1'b1) begin
            nerr++; $display("FAIL err_clear: err=%b busy=%b expected 0/1", s_err, s_busy);
        end
        cyc(1'b1, 1'b0);
        bits(32'h0, 4);
        bits(32'h01, 5);
        res(2);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_done !== 1'b1 || cq[0] != 2 || pq[0] != 1) begin
            nerr++; $display("FAIL err_recover: done=%b cnt=%0d param=%0d expected 1 2 1", s_done, cq[0], pq[0]);
        end
    endtask

    task automatic test_escape();
        clr();
        start(3'd0, 16'd4);
        bits(32'h0, 2);
        bits(32'h0, 4);
        bits(32'hF, 4);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_err !== 1'b1 || s_ren !== 1'b0) begin
            nerr++; $display("FAIL escape4: err=%b ren=%b expected 1/0", s_err, s_ren);
        end
        clr();
        start(3'd0, 16'd2);
        bits(32'h1, 2);
        bits(32'h0, 4);
        bits(32'h0F, 5);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_ren !== 1'b1 || s_rp !== 5'd15 || s_err !== 1'b0) begin
            nerr++; $display("FAIL rice5_param15: ren=%b rp=%0d err=%b expected 1 15 0", s_ren, s_rp, s_err);
        end
        cyc(1'b1, 1'b1);
        res(1);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_done !== 1'b1 || cq[0] != 2) begin
            nerr++; $display("FAIL rice5_done: done=%b cnt=%0d expected 1 2", s_done, cq[0]);
        end
    endtask

    task automatic test_empty_partition();
        clr();
        start(3'd4, 16'd16);
        bits(32'h0001, 16);
        bits(32'h0002, 16);
        bits(32'hFFFF, 16);
        bits(32'h7FFF, 16);
        bits(32'h0, 2);
        bits(32'h2, 4);
        bits(32'h1, 4);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_ren !== 1'b0 || s_rp !== 5'd1 || s_busy !== 1'b1) begin
            nerr++; $display("FAIL empty_skip: ren=%b rp=%0d busy=%b expected 0 1 1", s_ren, s_rp, s_busy);
        end
        bits(32'h2, 3);
        res(4);
        bits(32'h3, 4); res(4);
        bits(32'h4, 4); res(4);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_done !== 1'b1 || pq.size() != 3 || pq[0] != 2 || cq.size() != 3 || cq[0] != 4 || cq[2] != 4) begin
            nerr++; $display("FAIL empty_rest: done=%b np=%0d p0=%0d nc=%0d c0=%0d c2=%0d expected 1 3 2 3 4 4",
                             s_done, pq.size(), pq[0], cq.size(), cq[0], cq[2]);
        end
        ncmp++;
        if (n_pe != 16 || wq.size() != 4 || wq[2] !== 16'hFFFF || wq[3] !== 16'h7FFF) begin
            nerr++; $display("FAIL order4_warmup: pred=%0d nw=%0d w2=%h w3=%h expected 16 4 ffff 7fff",
                             n_pe, wq.size(), wq[2], wq[3]);
        end
        clr();
        start(3'd4, 16'd16);
        for (int k = 0; k < 4; k++) bits(32'h0, 16);
        bits(32'h0, 2);
        bits(32'h3, 4);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (s_err !== 1'b1 || s_busy !== 1'b0) begin
            nerr++; $display("FAIL underflow_err: err=%b busy=%b expected 1/0", s_err, s_busy);
        end
    endtask

    task automatic test_reset_mid();
        clr();
        start(3'd2, 16'd8);
        bits(32'h0005, 16);
        bits(32'hFFFB, 16);
        bits(32'h0, 2);
        bits(32'h0, 4);
        bits(32'h3, 4);
        res(3);
        iReset = 1'b0;
        cyc(1'b0, 1'b1);
        iReset = 1'b1;
        cyc(1'b0, 1'b1);
        ncmp++;
        if ({s_busy, s_wv, s_ren, s_pe, s_done, s_err} !== 6'b0 || s_ws !== 16'h0 || s_rp !== 5'h0) begin
            nerr++; $display("FAIL midreset_outputs: flags=%b ws=%h rp=%0d expected all zero",
                             {s_busy, s_wv, s_ren, s_pe, s_done, s_err}, s_ws, s_rp);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        ncmp++;
        if (n_done != 0) begin nerr++; $display("FAIL midreset_nodone: done=%0d expected 0", n_done); end
        run_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partitions();
        test_method_error();
        test_escape();
        test_empty_partition();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fixed_subframe_sequencer.md
# fixed_subframe_sequencer

Bit-serial control FSM for a FLAC SUBFRAME_FIXED. It parses the subframe's warm-up samples, the RESIDUAL header and each partition's Rice parameter directly from the bitstream. It hands the stream to the Rice residual decoder for exactly the right number of residuals per partition, and enables the fixed predictor for every sample. It sits between the frame-level parser, which supplies order and blocksize, and the Rice decoder/fixed-predictor datapath.

## Interface
Parameters:
- BPS, 16, bits per warm-up sample.
- BS_W, 16, blocksize width.

Ports:
- iClock  in  1  sole clock; all state changes on rising edge.
- iReset  in  1  synchronous, active-low reset.
- iStart  in  1  one-cycle pulse; latches iOrder and iBlockSize; ignored unless IDLE, DONE or ERROR.
- iOrder  in  3  predictor order, 0..4.
- iBlockSize  in  BS_W  samples in the subframe.
- iData  in  1  stream bit; one bit advances every cycle while oBusy.
- iRiceDone  in  1  Rice decoder pulse: the current cycle's bit completes one residual.
- oBusy  out  1  high in any state except IDLE/DONE/ERROR.
- oWarmupSample  out  BPS  assembled warm-up sample, MSB-first, two's complement.
- oWarmupValid  out  1  one-cycle pulse with oWarmupSample.
- oRiceParam  out  5  current partition's Rice parameter.
- oRiceEnable  out  1  the Rice decoder owns iData this cycle.
- oPredEnable  out  1  the predictor accepts a sample this cycle.
- oDone  out  1  one-cycle pulse after the last residual.
- oError  out  1  sticky until next accepted iStart.

## Operation
- States: IDLE, WARMUP, METHOD, PORDER, PARAM, RESIDUAL, DONE, ERROR.
- IDLE --iStart--> WARMUP, or METHOD if order=0.
- WARMUP: shift in order×BPS bits; pulse oWarmupValid after every BPS bits. After the last bit, go to METHOD.
- METHOD (2 bits):
  - 00 → 4-bit parameters; 01 → 5-bit parameters.
  - 1x → ERROR.
- PORDER (4 bits), value p; partitions = 2^p.
- Partition n sample count:
  - p=0: blocksize−order.
  - Partition 0 with p>0: (blocksize>>p)−order.
  - Otherwise: blocksize>>p.
- Count check: any count <0 → ERROR, entered straight from PORDER. This covers (blocksize>>p) < order.
- PARAM: read 4 or 5 bits MSB-first into oRiceParam.
  - All-ones (escape code, 1111 / 11111) → ERROR. Escape mode is unsupported.
  - Otherwise → RESIDUAL.
  - If the partition count is 0, skip RESIDUAL: go to the next PARAM, or DONE if this is the last partition.
- RESIDUAL: oRiceEnable=1; each iRiceDone decrements the remaining count.
  - On count 1→0 with more partitions: go to PARAM.
  - On the last partition: go to DONE.
- oPredEnable = oWarmupValid | (oRiceEnable & iRiceDone); this is its only combinational term.
- DONE: pulse oDone one cycle, then go to IDLE.
- ERROR: hold until iStart.
- iRiceDone outside RESIDUAL is ignored.

## Timing
- Reset, synchronous active-low: state IDLE; all outputs and counters 0. This includes oWarmupSample, oRiceParam, oError, oDone and oBusy.
- Reset mid-operation aborts decoding in the same edge; no oDone.
- A bit is sampled on the edge ending its cycle.
- oWarmupValid is high in the cycle after the last bit of a sample.
- Hand-off to the Rice decoder:
  - The edge sampling the last PARAM bit sets oRiceEnable=1.
  - The next cycle's bit belongs to the Rice decoder, with no gap.
- Hand-back from the Rice decoder:
  - The edge seeing the final iRiceDone of a partition clears oRiceEnable.
  - The next bit is the first bit of the following PARAM.
- Sample counts are computed in the PORDER→PARAM transition edge, BS_W wide and signed-checked. Subsequent counts are the registered blocksize>>p.
- Latency: oDone is one cycle after the edge that consumed the final residual's iRiceDone.
- iStart in the same cycle as a DONE→IDLE transition is accepted.

## Structure
- Shared package: state enum; method codes (RES_RICE4=2'b00, RES_RICE5=2'b01); escape constants (4'hF, 5'h1F); MAX_ORDER=4.
- One sub-module, partition_count: combinational {blocksize, p, order, first} → {count, underflow}.
- Remaining logic (FSM, bit counter, warm-up shifter, partition counter): roughly 200 lines.

## Test plan
- Order 2, blocksize 8, stream bits 0x0005, 0xFFFB, method 00, p=0, param 3; model 6 iRiceDone pulses.
  - Expect warm-up samples 5 and −5, then oRiceEnable for exactly 6 residuals.
  - Expect oPredEnable ×8 and oDone 1 cycle after the 6th pulse.
- Order 1, blocksize 16, p=2, params 2,3,4,5.
  - Expect counts 3,4,4,4 and oRiceParam updating before each RESIDUAL.
  - Expect zero idle cycles between phases.
- Method 10 → oError=1, oBusy=0. A later iStart clears oError.
- Param 1111 with method 00 → ERROR. Param 01111 with method 01 → RESIDUAL with oRiceParam=15.
- Order 4, blocksize 16, p=2 → partition 0 count 0: PARAM immediately followed by the next PARAM, no oRiceEnable. Same with p=3 (16>>3=2 < 4) → ERROR.
- iReset low during RESIDUAL → next cycle all outputs 0, IDLE. A new iStart decodes correctly.
